mult_share_ctrl: RTL and testbench

- Sequencing controller and two-port arbiter for the shared iterative 32x32 unsigned shift-add multiplier.
- Accepts operand pairs from two requesters using valid/ready handshakes and grants the multiplier round-robin.
- Pulses the multiplier's reset, holds the operands stable, and detects completion from res_ok, with a 32-cycle cap.
- Returns the 64-bit product tagged with the requester id on a valid/ready response port.

---
 rtl/mult_share_ctrl.sv | 153 +++++++++++++++
 tb/tb_mult_share_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl
//   Sequencing controller and two-port round-robin arbiter in front of one
//   shared iterative W x W unsigned shift-add multiplier.
//
//   Flow: IDLE grants one requester and latches its operands. LOAD pulses the
//   multiplier reset for one cycle. RUN waits for res_ok, or stops after
//   MAX_CYC cycles because res_ok never rises when opB[W-1] is set. DONE
//   presents the product until the consumer takes it.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   req0_valid/_a/_b/_ready requester 0 valid/ready operand port
//   req1_valid/_a/_b/_ready requester 1 valid/ready operand port
//   rsp_valid/_ready        product handshake
//   rsp_id                  requester that owns the product
//   rsp_data                2*W-bit unsigned product
//   mult_reset              reset to the shared multiplier
//   mult_opA, mult_opB      operands held stable for the multiplier
//   mult_res, mult_res_ok   multiplier result (top bit unused) and done flag
//   busy                    controller is not idle
module mult_share_ctrl #(
  parameter int W       = 32,
  parameter int MAX_CYC = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req1_ready,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_data,
  output logic           mult_reset,
  output logic [W-1:0]   mult_opA,
  output logic [W-1:0]   mult_opB,
  input  logic [2*W:0]   mult_res,
  input  logic           mult_res_ok,
  output logic           busy
);

  localparam int            CW  = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] CAP = CW'(MAX_CYC);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic             rr_ptr;
  logic [CW-1:0]    run_cnt;
  logic [W-1:0]     opA_r;
  logic [W-1:0]     opB_r;
  logic             id_r;
  logic [2*W-1:0]   rsp_data_r;
  logic             rsp_id_r;

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             run_exit;

  // The multiplier's extra carry bit never carries product information.
  logic             unused_res_msb;
  assign unused_res_msb = mult_res[2*W];

  // Arbitration: a lone requester wins; on contention rr_ptr decides.
  // Suppressed during reset so nothing is accepted while the block clears.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~rr_ptr;
        grant1 = rr_ptr;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign accept   = grant0 | grant1;
  assign run_exit = mult_res_ok || (run_cnt == CAP);

  // Next state and outputs
  always_comb begin
    state_nx   = state;
    req0_ready = grant0;
    req1_ready = grant1;
    mult_reset = reset;
    rsp_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: if (accept) state_nx = LOAD;
      LOAD: begin
        mult_reset = 1'b1;
        state_nx   = RUN;
      end
      RUN:  if (run_exit) state_nx = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mult_opA = opA_r;
  assign mult_opB = opB_r;
  assign rsp_data = rsp_data_r;
  assign rsp_id   = rsp_id_r;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      run_cnt    <= '0;
      opA_r      <= '0;
      opB_r      <= '0;
      id_r       <= 1'b0;
      rsp_data_r <= '0;
      rsp_id_r   <= 1'b0;
    end else begin
      state <= state_nx;

      if (accept) begin
        opA_r  <= grant1 ? req1_a : req0_a;
        opB_r  <= grant1 ? req1_b : req0_b;
        id_r   <= grant1;
        rr_ptr <= ~grant1;
      end

      // run_cnt equals the number of steps the multiplier has taken.
      if (state == LOAD) begin
        run_cnt <= '0;
      end else if (state == RUN && !run_exit) begin
        run_cnt <= run_cnt + 1'b1;
      end

      if (state == RUN && run_exit) begin
        rsp_data_r <= mult_res[2*W-1:0];
        rsp_id_r   <= id_r;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
module tb_mult_share_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [63:0] rsp_data;
  logic        mult_reset;
  logic [31:0] mult_opA, mult_opB;
  logic [64:0] mult_res;
  logic        mult_res_ok;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mult_share_ctrl #(.W(32), .MAX_CYC(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .mult_reset(mult_reset), .mult_opA(mult_opA), .mult_opB(mult_opB),
    .mult_res(mult_res), .mult_res_ok(mult_res_ok), .busy(busy)
  );

  // Behavioural shift-add multiplier: after k steps it holds A*(B mod 2^k);
  // done once every set bit of B is consumed, except that B[31]=1 wraps its
  // counter so done never rises.
  int unsigned steps;

  function automatic int nbits(input logic [63:0] v);
    return $clog2(v + 64'd1);
  endfunction

  function automatic logic [63:0] partial(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned k);
    logic [63:0] m;
    if (k >= 32) m = {32'd0, b};
    else         m = {32'd0, b} & ((64'd1 << k) - 64'd1);
    return {32'd0, a} * m;
  endfunction

  always @(posedge clk) begin
    if (mult_reset)        steps <= 0;
    else if (steps < 1000) steps <= steps + 1;
  end

  assign mult_res    = {steps[0], partial(mult_opA, mult_opB, steps)};
  assign mult_res_ok = !mult_opB[31] && (steps >= nbits({32'd0, mult_opB}));

  // Present one operand pair, wait for acceptance, measure cycles from the
  // accepting edge to rsp_valid and capture the response.
  task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] data, output logic rid,
                        output bit ok);
    int n;
    ok = 1'b1;
    if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    n = 0;
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready)) begin
      n++;
      if (n > 100) begin ok = 1'b0; break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    lat  = 0;
    data = '0;
    rid  = 1'b0;
    if (ok) begin
      @(negedge clk);
      while (!rsp_valid) begin
        lat++;
        if (lat > 60) begin ok = 1'b0; break; end
        @(negedge clk);
      end
      data = rsp_data;
      rid  = rsp_id;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9;
    req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (mult_reset !== 1'b1) begin fails++; $display("FAIL reset_mult_reset: got %b expected 1", mult_reset); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
    checks++; if ({mult_opA, mult_opB} !== 64'd0) begin fails++; $display("FAIL reset_ops: got %h expected 0", {mult_opA, mult_opB}); end
    checks++; if ({rsp_id, rsp_data} !== 65'd0) begin fails++; $display("FAIL reset_rsp: got %h expected 0", {rsp_id, rsp_data}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (mult_reset !== 1'b0) begin fails++; $display("FAIL idle_mult_reset: got %b expected 0", mult_reset); end
  endtask

  task automatic test_single();
    int lat; logic [63:0] d; logic rid; bit ok;
    rsp_ready = 1'b1;
    run_op(1'b0, 32'd78319, 32'd54491, lat, d, rid, ok);
    checks++; if (!ok) begin fails++; $display("FAIL single_timeout: got timeout expected response"); end
    checks++; if (lat !== 18) begin fails++; $display("FAIL single_latency: got %0d expected 18", lat); end
    checks++; if (d !== 64'd4267680629) begin fails++; $display("FAIL single_data: got %0d expected 4267680629", d); end
    checks++; if (rid !== 1'b0) begin fails++; $display("FAIL single_id: got %b expected 0", rid); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int lat; logic [63:0] d; logic rid; bit ok;
    rsp_ready = 1'b1;
    run_op(1'b0, 32'hDEADBEEF, 32'd0, lat, d, rid, ok);
    checks++; if (!ok || lat !== 2 || d !== 64'd0) begin fails++; $display("FAIL zero_b: got ok=%0d lat=%0d data=%0d expected ok=1 lat=2 data=0", ok, lat, d); end
    @(posedge clk); #1;
    run_op(1'b1, 32'd0, 32'd1, lat, d, rid, ok);
    checks++; if (!ok || lat !== 3 || d !== 64'd0 || rid !== 1'b1) begin fails++; $display("FAIL zero_a: got ok=%0d lat=%0d data=%0d id=%b expected ok=1 lat=3 data=0 id=1", ok, lat, d, rid); end
    @(posedge clk); #1;
  endtask

  task automatic test_cap();
    int lat; logic [63:0] d; logic rid; bit ok;
    rsp_ready = 1'b1;
    run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, d, rid, ok);
    checks++; if (!ok || lat !== 34) begin fails++; $display("FAIL cap_latency: got ok=%0d lat=%0d expected ok=1 lat=34", ok, lat); end
    checks++; if (d !== 64'hFFFFFFFE00000001) begin fails++; $display("FAIL cap_data: got %h expected fffffffe00000001", d); end
    checks++; if (rid !== 1'b1) begin fails++; $display("FAIL cap_id: got %b expected 1", rid); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; logic [63:0] d; logic rid; bit ok;
    logic [31:0] a, b; bit id; int exp_lat; logic [63:0] exp_d;
    rsp_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 32);
      if (i == 3) b = 32'h80000000;
      id = $urandom_range(0, 1);
      exp_lat = nbits({32'd0, b}) + 2;
      exp_d   = {32'd0, a} * {32'd0, b};
      run_op(id, a, b, lat, d, rid, ok);
      checks++;
      if (!ok || lat !== exp_lat || d !== exp_d || rid !== id) begin
        fails++;
        $display("FAIL random_op%0d: got ok=%0d lat=%0d data=%h id=%b expected ok=1 lat=%0d data=%h id=%b",
                 i, ok, lat, d, rid, exp_lat, exp_d, id);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_arbitration();
    bit exp_grant; int grants; int rsps; bit pend[$]; bit g; bit bad_ready;
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    rsp_ready = 1'b1;
    req0_a = 32'd3; req0_b = 32'd5; req1_a = 32'd7; req1_b = 32'd11;
    req0_valid = 1'b1; req1_valid = 1'b1;
    exp_grant = 1'b0; grants = 0; rsps = 0; bad_ready = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (busy && (req0_ready || req1_ready)) bad_ready = 1'b1;
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (pend.size() == 0) begin
          fails++; $display("FAIL arb_unexpected_rsp: got response id=%b expected none", rsp_id);
        end else begin
          g = pend.pop_front();
          if (rsp_id !== g || rsp_data !== (g ? 64'd77 : 64'd15)) begin
            fails++;
            $display("FAIL arb_rsp: got id=%b data=%0d expected id=%b data=%0d", rsp_id, rsp_data, g, g ? 77 : 15);
          end
        end
        rsps++;
      end
      if (req0_ready || req1_ready) begin
        checks++;
        if ((req0_ready && req1_ready) || (req1_ready !== exp_grant)) begin
          fails++;
          $display("FAIL arb_grant%0d: got ready=%b%b expected grant %0d", grants, req1_ready, req0_ready, exp_grant);
        end
        pend.push_back(exp_grant);
        exp_grant = ~exp_grant;
        grants++;
      end
    end
    checks++; if (bad_ready) begin fails++; $display("FAIL arb_ready_busy: got ready while busy expected none"); end
    checks++; if (grants < 6 || rsps < 5) begin fails++; $display("FAIL arb_progress: got grants=%0d rsps=%0d expected >=6 and >=5", grants, rsps); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat; logic [63:0] d; logic rid; bit ok; bit bad;
    rsp_ready = 1'b0;
    run_op(1'b0, 32'd6, 32'd7, lat, d, rid, ok);
    checks++; if (!ok || lat !== 5 || d !== 64'd42) begin fails++; $display("FAIL bp_first: got ok=%0d lat=%0d data=%0d expected ok=1 lat=5 data=42", ok, lat, d); end
    req1_a = 32'd1; req1_b = 32'd1; req1_valid = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 64'd42 || rsp_id !== 1'b0 || req1_ready !== 1'b0 || mult_reset !== 1'b0) begin
        fails++; bad = 1'b1;
        $display("FAIL bp_hold%0d: got valid=%b data=%0d id=%b ready1=%b mrst=%b expected 1/42/0/0/0",
                 c, rsp_valid, rsp_data, rsp_id, req1_ready, mult_reset);
      end
    end
    rsp_ready = 1'b1;
    run_op(1'b1, 32'd1, 32'd1, lat, d, rid, ok);
    checks++; if (!ok || lat !== 3 || d !== 64'd1 || rid !== 1'b1) begin fails++; $display("FAIL bp_next: got ok=%0d lat=%0d data=%0d id=%b expected ok=1 lat=3 data=1 id=1", ok, lat, d, rid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [63:0] d; logic rid; bit ok; int n;
    rsp_ready = 1'b1;
    req0_a = 32'd1000; req0_b = 32'h80000000; req0_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req0_ready && n < 100) begin n++; @(negedge clk); end
    checks++; if (n >= 100) begin fails++; $display("FAIL mid_accept: got timeout expected ready"); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b expected 1", busy); end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || mult_reset !== 1'b1) begin
        fails++;
        $display("FAIL mid_reset%0d: got busy=%b valid=%b mrst=%b expected 0/0/1", c, busy, rsp_valid, mult_reset);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(1'b1, 32'd2, 32'd3, lat, d, rid, ok);
    checks++; if (!ok || lat !== 4 || d !== 64'd6 || rid !== 1'b1) begin fails++; $display("FAIL mid_after: got ok=%0d lat=%0d data=%0d id=%b expected ok=1 lat=4 data=6 id=1", ok, lat, d, rid); end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_cap();
    test_random();
    test_arbitration();
    test_backpressure();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
